// File: rtl/data_mem_arb_pkg.sv
// Shared types and grant encodings for the data memory arbiter.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_CPU, OWN_EXT} owner_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_EXT  = 2'b10;

  function automatic logic [1:0] grant_code(input owner_t o);
    return (o == OWN_EXT) ? GRANT_EXT : GRANT_CPU;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr_arbiter_2
  import data_mem_arb_pkg::*;
(
  input  logic   req_cpu,
  input  logic   req_ext,
  input  owner_t last_grant,
  output logic   valid,
  output owner_t winner
);

  always_comb begin
    valid  = req_cpu | req_ext;
    winner = OWN_CPU;
    if (req_cpu && req_ext)
      winner = (last_grant == OWN_CPU) ? OWN_EXT : OWN_CPU;
    else if (req_ext)
      winner = OWN_EXT;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one multi-cycle data memory between the CPU and an external port,
// stalling the CPU until its own access completes.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int ADDR_LENGTH = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_write,
  input  logic [ADDR_LENGTH-1:0] cpu_addr,
  input  logic [WORD_LENGTH-1:0] cpu_wdata,
  output logic [WORD_LENGTH-1:0] cpu_rdata,
  output logic                   cpu_ready,
  output logic                   cpu_stall,
  input  logic                   ext_req,
  input  logic                   ext_write,
  input  logic [ADDR_LENGTH-1:0] ext_addr,
  input  logic [WORD_LENGTH-1:0] ext_wdata,
  output logic [WORD_LENGTH-1:0] ext_rdata,
  output logic                   ext_ready,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  output logic                   mem_read,
  output logic                   mem_write,
  input  logic [WORD_LENGTH-1:0] mem_rdata,
  output logic                   busy,
  output logic [1:0]             grant
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t   state;
  owner_t   owner, last_grant, winner;
  logic     wr, win_valid;
  logic [3:0] cnt;

  logic                   sel_write;
  logic [ADDR_LENGTH-1:0] sel_addr;
  logic [WORD_LENGTH-1:0] sel_wdata;

  rr_arbiter_2 u_arb (
    .req_cpu    (cpu_req),
    .req_ext    (ext_req),
    .last_grant (last_grant),
    .valid      (win_valid),
    .winner     (winner)
  );

  always_comb begin
    sel_write = cpu_write;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (winner == OWN_EXT) begin
      sel_write = ext_write;
      sel_addr  = ext_addr;
      sel_wdata = ext_wdata;
    end
  end

  assign busy      = (state != IDLE);
  assign cpu_stall = cpu_req & ~cpu_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      last_grant <= OWN_EXT;
      wr         <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
      cpu_ready  <= 1'b0;
      ext_ready  <= 1'b0;
      grant      <= GRANT_NONE;
    end else begin
      cpu_ready <= 1'b0;
      ext_ready <= 1'b0;
      case (state)
        IDLE: if (win_valid) begin
          owner     <= winner;
          wr        <= sel_write;
          mem_addr  <= sel_addr;
          mem_wdata <= sel_wdata;
          cnt       <= CNT_INIT;
          grant     <= grant_code(winner);
          // Strobes are registered, so they are set here to line up with ACCESS.
          mem_read  <= ~sel_write;
          mem_write <= sel_write;
          state     <= ACCESS;
        end
        ACCESS: begin
          mem_write <= 1'b0;
          if (cnt == 4'd0) begin
            mem_read   <= 1'b0;
            last_grant <= owner;
            if (!wr && owner == OWN_CPU) cpu_rdata <= mem_rdata;
            if (!wr && owner == OWN_EXT) ext_rdata <= mem_rdata;
            cpu_ready  <= (owner == OWN_CPU);
            ext_ready  <= (owner == OWN_EXT);
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          grant <= GRANT_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench: stimulus pushes expected responses, a negedge monitor pops and checks.
module tb_data_mem_arbiter;
  import data_mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cpu_req, cpu_write, ext_req, ext_write;
  logic [7:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [7:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       cpu_ready, cpu_stall, ext_ready, mem_read, mem_write, busy;
  logic [1:0] grant;

  logic       c1_req, c1_write, e1_req, e1_write;
  logic [7:0] c1_addr, c1_wdata, e1_addr, e1_wdata;
  logic [7:0] c1_rdata, e1_rdata, m1_addr, m1_wdata, m1_rdata;
  logic       c1_ready, c1_stall, e1_ready, m1_read, m1_write, b1;
  logic [1:0] g1;

  data_mem_arbiter #(.WORD_LENGTH(8), .ADDR_LENGTH(8), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_write(ext_write), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ready(ext_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
  );

  data_mem_arbiter #(.WORD_LENGTH(8), .ADDR_LENGTH(8), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(c1_req), .cpu_write(c1_write), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_rdata(c1_rdata), .cpu_ready(c1_ready), .cpu_stall(c1_stall),
    .ext_req(e1_req), .ext_write(e1_write), .ext_addr(e1_addr), .ext_wdata(e1_wdata),
    .ext_rdata(e1_rdata), .ext_ready(e1_ready),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_read(m1_read), .mem_write(m1_write),
    .mem_rdata(m1_rdata), .busy(b1), .grant(g1)
  );

  // Combinational-read memory models; each is owned by a single process.
  logic [7:0] mem [256];
  logic [7:0] mem1 [256];
  assign mem_rdata = mem[mem_addr];
  assign m1_rdata  = mem1[m1_addr];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    forever @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem1[i] = 8'h00;
    mem1[8'h10] = 8'h3C;
    forever @(posedge clk) if (m1_write) mem1[m1_addr] <= m1_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       chk;
    logic [7:0] data;
  } exp_t;

  exp_t   cpu_q[$];
  exp_t   ext_q[$];
  owner_t log_q[$];
  exp_t   me;
  int     cpu_rdy_cyc, ext_rdy_cyc;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_ready) begin
        cpu_rdy_cyc = cyc;
        log_q.push_back(OWN_CPU);
        check("cpu_ready_grant", grant, GRANT_CPU);
        check("cpu_stall_at_ready", cpu_stall, 1'b0);
        if (cpu_q.size() == 0) check("cpu_unexpected_ready", 1, 0);
        else begin
          me = cpu_q.pop_front();
          if (me.chk) check("cpu_rdata", cpu_rdata, me.data);
        end
      end
      if (ext_ready) begin
        ext_rdy_cyc = cyc;
        log_q.push_back(OWN_EXT);
        check("ext_ready_grant", grant, GRANT_EXT);
        if (ext_q.size() == 0) check("ext_unexpected_ready", 1, 0);
        else begin
          me = ext_q.pop_front();
          if (me.chk) check("ext_rdata", ext_rdata, me.data);
        end
      end
    end
  end

  // One transaction: drive req, count strobes until ready, drop req after the ready cycle.
  task automatic txn(input bit is_ext, input bit w, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] exp_d, output int lat, output int nrd,
                     output int nwr, output int nstall);
    exp_t e;
    bit   rdy;
    e.chk = !w; e.data = exp_d;
    lat = -1; nrd = 0; nwr = 0; nstall = 0;
    if (is_ext) begin
      ext_q.push_back(e);
      ext_write = w; ext_addr = a; ext_wdata = d; ext_req = 1'b1;
    end else begin
      cpu_q.push_back(e);
      cpu_write = w; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rdy = is_ext ? ext_ready : cpu_ready;
      if (rdy) begin lat = i; break; end
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      nstall += int'(cpu_stall);
    end
    @(posedge clk); #1;
    if (is_ext) ext_req = 1'b0; else cpu_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int lat, nrd, nwr, nst, lat2, d1, d2, d3, d4, nrdy, r1a, r1b;

  initial begin
    rst = 1'b1;
    cpu_req = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_write = 0; ext_addr = 0; ext_wdata = 0;
    c1_req = 0; c1_write = 0; c1_addr = 0; c1_wdata = 0;
    e1_req = 0; e1_write = 0; e1_addr = 0; e1_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, GRANT_NONE);
    check("rst_strobes", {mem_read, mem_write}, 2'b00);
    check("rst_ready", {cpu_ready, ext_ready}, 2'b00);
    check("rst_cpu_rdata", cpu_rdata, 8'h00);
    check("rst_ext_rdata", ext_rdata, 8'h00);
    @(posedge clk); #1;

    // Single CPU read
    txn(0, 0, 8'h10, 8'h00, 8'h5A, lat, nrd, nwr, nst);
    check("cpu_read_latency", lat, 3);
    check("cpu_read_mem_read_cycles", nrd, 2);
    check("cpu_read_mem_write_cycles", nwr, 0);
    check("cpu_read_stall_cycles", nst, 3);

    // External write then CPU read-back
    txn(1, 1, 8'h20, 8'hC3, 8'h00, lat, nrd, nwr, nst);
    check("ext_write_latency", lat, 3);
    check("ext_write_mem_write_cycles", nwr, 1);
    check("ext_write_mem_read_cycles", nrd, 0);
    txn(0, 0, 8'h20, 8'h00, 8'hC3, lat, nrd, nwr, nst);
    check("cpu_readback_latency", lat, 3);
    check("ext_rdata_unchanged", ext_rdata, 8'h00);

    // Simultaneous requests right after reset
    do_reset();
    log_q.delete();
    fork
      txn(0, 0, 8'h10, 8'h00, 8'h5A, lat, nrd, nwr, nst);
      txn(1, 0, 8'h10, 8'h00, 8'h5A, lat2, d1, d2, d3);
    join
    check("tie_cpu_latency", lat, 3);
    check("tie_ext_after_cpu", ext_rdy_cyc - cpu_rdy_cyc, 4);
    check("tie_log_size", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("tie_first_cpu", log_q[0], OWN_CPU);
      check("tie_second_ext", log_q[1], OWN_EXT);
    end

    // Both held continuously for six transactions
    log_q.delete();
    for (int i = 0; i < 3; i++) begin
      cpu_q.push_back('{chk: 1'b1, data: 8'h5A});
      ext_q.push_back('{chk: 1'b1, data: 8'hC3});
    end
    cpu_write = 0; cpu_addr = 8'h10; ext_write = 0; ext_addr = 8'h20;
    cpu_req = 1; ext_req = 1;
    for (int i = 0; i < 100 && log_q.size() < 6; i++) @(negedge clk);
    @(posedge clk); #1;
    cpu_req = 0; ext_req = 0;
    check("cont_count", log_q.size(), 6);
    if (log_q.size() >= 6) begin
      check("cont_first_cpu", log_q[0], OWN_CPU);
      for (int i = 1; i < 6; i++) check("cont_alternate", log_q[i] == log_q[i-1], 1'b0);
    end

    // Reset during the second ACCESS cycle of a CPU write
    cpu_write = 1; cpu_addr = 8'h30; cpu_wdata = 8'h77; cpu_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_access", busy, 1'b1);
    rst = 1; cpu_req = 0;
    @(posedge clk); #1;
    rst = 0;
    check("abort_idle", busy, 1'b0);
    check("abort_strobes", {mem_read, mem_write}, 2'b00);
    check("abort_grant", grant, GRANT_NONE);
    nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nrdy += int'(cpu_ready);
    end
    check("abort_no_ready", nrdy, 0);
    @(posedge clk); #1;

    // MEM_LATENCY = 1 with CPU req held past ready
    r1a = -1; r1b = -1;
    c1_write = 0; c1_addr = 8'h10; c1_req = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (c1_ready) begin
        check("lat1_rdata", c1_rdata, 8'h3C);
        if (r1a < 0) r1a = i;
        else begin r1b = i; break; end
      end
    end
    @(posedge clk); #1;
    c1_req = 0;
    check("lat1_first_latency", r1a, 2);
    check("lat1_ready_spacing", r1b - r1a, 3);
    repeat (4) @(posedge clk);
    #1;
    check("lat1_idle", b1, 1'b0);

    check("cpu_queue_drained", cpu_q.size(), 0);
    check("ext_queue_drained", ext_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data memory between two requesters: the CPU datapath port and an external port (loader/debug/DMA).
- Each requester uses a req/ready handshake.
- A round-robin FSM sequences multi-cycle memory accesses and raises a stall to the CPU control path so the PC and register-file write are frozen until the CPU access completes.

Parameters:
WORD_LENGTH, 8, data width
ADDR_LENGTH, 8, address width
MEM_LATENCY, 2, cycles the memory needs per access (legal range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU access request, held until cpu_ready
cpu_write  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_LENGTH  CPU address
cpu_wdata  in  WORD_LENGTH  CPU write data
cpu_rdata  out  WORD_LENGTH  CPU read data, registered
cpu_ready  out  1  one-cycle completion pulse
cpu_stall  out  1  cpu_req & ~cpu_ready (combinational)
ext_req  in  1  external access request
ext_write  in  1  1 = write
ext_addr  in  ADDR_LENGTH  external address
ext_wdata  in  WORD_LENGTH  external write data
ext_rdata  out  WORD_LENGTH  external read data, registered
ext_ready  out  1  one-cycle completion pulse
mem_addr  out  ADDR_LENGTH  to memory
mem_wdata  out  WORD_LENGTH  to memory
mem_read  out  1  read strobe
mem_write  out  1  write strobe
mem_rdata  in  WORD_LENGTH  from memory
busy  out  1  state != IDLE
grant  out  2  01 = CPU, 10 = EXT, 00 = none

Behaviour:
- Reset applies to every register:
  - state = IDLE, last_grant = EXT (so CPU wins the first tie).
  - cnt = 0; cpu_rdata = ext_rdata = 0; ready pulses 0.
  - mem_read = mem_write = 0, grant = 00, busy = 0.
  - A reset arriving mid-access aborts the access; no ready pulse is issued afterwards.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the one opposite to last_grant.
  - On grant: latch owner, write flag, addr and wdata into internal registers; set cnt = MEM_LATENCY-1; go to ACCESS.
- ACCESS:
  - mem_addr and mem_wdata come from the latched registers, stable for the whole access.
  - mem_read = ~write for every ACCESS cycle.
  - mem_write = write on the first ACCESS cycle only, giving exactly one write per transaction.
  - cnt decrements each cycle.
  - When cnt == 0: capture mem_rdata into the owner's rdata register (reads only), update last_grant = owner, go to RESP.
- RESP:
  - The owner's ready is 1 for exactly this cycle; mem strobes are 0.
  - Next state is IDLE.
  - The arbiter does not start a new grant in RESP.
- Latency: req sampled high in IDLE at cycle T gives ACCESS cycles T+1..T+MEM_LATENCY, ready at T+MEM_LATENCY+1, IDLE at T+MEM_LATENCY+2.
- Minimum spacing between back-to-back transactions is MEM_LATENCY+2 cycles.
- Requester rules:
  - Hold req and its fields stable until ready.
  - Deassert req in the cycle after ready. A req still high in IDLE is a new transaction.
  - Dropping req during ACCESS does not cancel the access; it completes and ready still pulses.
- rdata holds its value until the next read completed for that same requester. Writes do not modify rdata.
- Outside ACCESS: grant = 00 in IDLE and holds the owner's code in ACCESS and RESP. mem_addr and mem_wdata keep their last latched values.
- Fairness: with both requesters asserting continuously, grants strictly alternate, so neither waits more than one transaction.

Decomposition:
- Shared package data_mem_arb_pkg holds:
  - typedef enum state_t {IDLE, ACCESS, RESP};
  - typedef enum owner_t {OWN_CPU, OWN_EXT};
  - constants GRANT_NONE = 2'b00, GRANT_CPU = 2'b01, GRANT_EXT = 2'b10.
- One sub-module, rr_arbiter_2 (combinational), computes the winner from req_cpu, req_ext and last_grant.
- The FSM, counter and latches stay in data_mem_arbiter.

Test Plan:
- Reset, then single CPU read at addr 0x10 (memory holds 0x5A), MEM_LATENCY = 2:
  - mem_read high for 2 cycles.
  - cpu_ready pulses at T+3 with cpu_rdata = 0x5A.
  - cpu_stall high T..T+2.
- External write 0xC3 to 0x20, then CPU read 0x20:
  - mem_write high for exactly 1 cycle.
  - The CPU read returns 0xC3.
  - ext_rdata is unchanged (0).
- Both req asserted at the same cycle right after reset:
  - CPU granted first, EXT second, grant sequence 01 then 10.
  - ext_ready arrives 4 cycles after cpu_ready.
- Both req held continuously for 6 transactions: grants alternate CPU, EXT, CPU, ... with no requester served twice in a row.
- rst asserted in the second ACCESS cycle of a CPU write:
  - Next cycle shows state IDLE, all strobes 0, grant 00.
  - No cpu_ready pulse follows.
- MEM_LATENCY = 1, CPU req held high past ready: a second access starts; cycle spacing between ready pulses = 3.
